// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory/writeback pipeline stage.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WB
  } state_t;

  localparam int unsigned DEF_ADDR_W      = 8;
  localparam int unsigned DEF_TIMEOUT_CYC = 16;
  localparam logic [4:0]  REG_ZERO        = 5'd0;

endpackage

// File: rtl/mem_access_timer.sv
// Watchdog counter for an outstanding data-memory access (built only with MEM_TIMEOUT_EN).
module mem_access_timer
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic ack,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt;

  // Held at zero outside ACCESS, so every access starts counting from zero.
  always_ff @(posedge clk) begin
    if (rst || !active) begin
      cnt <= '0;
    end else if (!ack) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Fires in the last allowed req cycle; an ack in that same cycle wins.
  assign expired = active && !ack && (cnt == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access / writeback stage: req/ack data-memory handshake then register-file write.
// Optional access watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_wb_stage
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [31:0]       alu_res,
  input  logic [31:0]       write_data,
  input  logic              reg_wrenable,
  input  logic [4:0]        write_reg,
  input  logic              mem_wrenable,
  input  logic              mem_to_reg,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic              wb_en,
  output logic [4:0]        wb_reg,
  output logic [31:0]       wb_data,
  output logic              mem_err
);

  if (ADDR_W < 1 || ADDR_W > 32 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("mem_wb_stage: ADDR_W must be 1..32 and TIMEOUT_CYC at least 1");
  end

  state_t state, state_n;

  logic [31:0] r_alu;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [4:0]  r_reg;
  logic        r_rwe;
  logic        r_mwe;
  logic        r_m2r;

  logic accept;
  logic in_access;
  logic r_load;
  logic timeout;

  assign in_access = (state == ACCESS);
  assign ex_ready  = !rst && !in_access;
  assign accept    = ex_valid && ex_ready;
  // Store takes priority when both memory bits are set.
  assign r_load    = r_m2r && !r_mwe;

`ifdef MEM_TIMEOUT_EN
  mem_access_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .active (in_access),
    .ack    (dmem_ack),
    .expired(timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_err <= 1'b0;
    end else if (timeout) begin
      mem_err <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign mem_err = 1'b0;
`endif

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, WB: begin
        if (accept) begin
          state_n = (mem_wrenable || mem_to_reg) ? ACCESS : WB;
        end else begin
          state_n = IDLE;
        end
      end
      ACCESS: begin
        if (dmem_ack) begin
          state_n = WB;
        end else if (timeout) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      r_alu   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_reg   <= '0;
      r_rwe   <= 1'b0;
      r_mwe   <= 1'b0;
      r_m2r   <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        r_alu   <= alu_res;
        r_wdata <= write_data;
        r_reg   <= write_reg;
        r_rwe   <= reg_wrenable;
        r_mwe   <= mem_wrenable;
        r_m2r   <= mem_to_reg;
      end
      if (in_access && dmem_ack && r_load) begin
        r_rdata <= dmem_rdata;
      end
    end
  end

  assign dmem_req   = in_access;
  assign dmem_we    = in_access && r_mwe;
  assign dmem_addr  = r_alu[ADDR_W-1:0];
  assign dmem_wdata = r_wdata;

  assign wb_en   = (state == WB) && r_rwe && (r_reg != REG_ZERO);
  assign wb_reg  = r_reg;
  assign wb_data = r_load ? r_rdata : r_alu;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage (default or MEM_TIMEOUT_EN build).
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] alu_res;
  logic [31:0] write_data;
  logic        reg_wrenable;
  logic [4:0]  write_reg;
  logic        mem_wrenable;
  logic        mem_to_reg;
  logic        dmem_req;
  logic        dmem_we;
  logic [7:0]  dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        mem_err;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(
    .ADDR_W(8),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .alu_res(alu_res), .write_data(write_data), .reg_wrenable(reg_wrenable),
    .write_reg(write_reg), .mem_wrenable(mem_wrenable), .mem_to_reg(mem_to_reg),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data), .mem_err(mem_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bundle(input logic [31:0] a, input logic [31:0] wd, input logic rwe,
                        input logic [4:0] rd, input logic mwe, input logic m2r);
    ex_valid     = 1'b1;
    alu_res      = a;
    write_data   = wd;
    reg_wrenable = rwe;
    write_reg    = rd;
    mem_wrenable = mwe;
    mem_to_reg   = m2r;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(ex_ready), 32'd0);
    check({tag, "_req"},   32'(dmem_req), 32'd0);
    check({tag, "_we"},    32'(dmem_we), 32'd0);
    check({tag, "_addr"},  32'(dmem_addr), 32'd0);
    check({tag, "_wdata"}, dmem_wdata, 32'd0);
    check({tag, "_wben"},  32'(wb_en), 32'd0);
    check({tag, "_wbreg"}, 32'(wb_reg), 32'd0);
    check({tag, "_wbdata"}, wb_data, 32'd0);
    check({tag, "_err"},   32'(mem_err), 32'd0);
  endtask

  logic [31:0] b2b_alu [4];
  logic [4:0]  b2b_reg [4];

  initial begin
    rst = 1'b1; ex_valid = 1'b0; alu_res = '0; write_data = '0;
    reg_wrenable = 1'b0; write_reg = '0; mem_wrenable = 1'b0; mem_to_reg = 1'b0;
    dmem_rdata = '0; dmem_ack = 1'b0;

    // Reset state
    tick(); tick();
    check_all_zero("reset");
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(ex_ready), 32'd1);

    // ALU op
    bundle(32'h1234, 32'h0, 1'b1, 5'd3, 1'b0, 1'b0);
    tick();
    ex_valid = 1'b0;
    check("alu_wben", 32'(wb_en), 32'd1);
    check("alu_wbreg", 32'(wb_reg), 32'd3);
    check("alu_wbdata", wb_data, 32'h1234);
    check("alu_req", 32'(dmem_req), 32'd0);
    tick();
    check("alu_wben_off", 32'(wb_en), 32'd0);
    check("alu_req_off", 32'(dmem_req), 32'd0);

    // Store, ack in 3rd req cycle
    bundle(32'h5, 32'hCAFEF00D, 1'b0, 5'd7, 1'b1, 1'b0);
    tick();
    ex_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      check("st_req", 32'(dmem_req), 32'd1);
      check("st_we", 32'(dmem_we), 32'd1);
      check("st_addr", 32'(dmem_addr), 32'h5);
      check("st_wdata", dmem_wdata, 32'hCAFEF00D);
      check("st_ready", 32'(ex_ready), 32'd0);
      check("st_wben", 32'(wb_en), 32'd0);
      if (k == 3) dmem_ack = 1'b1;
      tick();
    end
    dmem_ack = 1'b0;
    check("st_req_done", 32'(dmem_req), 32'd0);
    check("st_no_wb", 32'(wb_en), 32'd0);
    check("st_ready_wb", 32'(ex_ready), 32'd1);
    tick();

    // Load, ack in first req cycle
    bundle(32'h7, 32'h0, 1'b1, 5'd9, 1'b0, 1'b1);
    tick();
    ex_valid = 1'b0;
    check("ld_req", 32'(dmem_req), 32'd1);
    check("ld_we", 32'(dmem_we), 32'd0);
    check("ld_addr", 32'(dmem_addr), 32'h7);
    dmem_ack = 1'b1; dmem_rdata = 32'hA5A50001;
    tick();
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    check("ld_wben", 32'(wb_en), 32'd1);
    check("ld_wbreg", 32'(wb_reg), 32'd9);
    check("ld_wbdata", wb_data, 32'hA5A50001);
    check("ld_req_off", 32'(dmem_req), 32'd0);
    tick();
    check("ld_wben_off", 32'(wb_en), 32'd0);

    // Store + load bits together: treated as store, writes alu_res
    bundle(32'h11, 32'hDEAD, 1'b1, 5'd2, 1'b1, 1'b1);
    tick();
    ex_valid = 1'b0;
    check("both_we", 32'(dmem_we), 32'd1);
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    tick();
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    check("both_wben", 32'(wb_en), 32'd1);
    check("both_wbdata", wb_data, 32'h11);
    tick();

    // Stray ack while idle is ignored
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    check("stray_ack_wben", 32'(wb_en), 32'd0);
    check("stray_ack_req", 32'(dmem_req), 32'd0);

    // Four back-to-back ALU ops, first targets r0
    b2b_alu[0] = 32'h100; b2b_reg[0] = 5'd0;
    b2b_alu[1] = 32'h200; b2b_reg[1] = 5'd4;
    b2b_alu[2] = 32'h300; b2b_reg[2] = 5'd5;
    b2b_alu[3] = 32'h400; b2b_reg[3] = 5'd31;
    for (int i = 0; i < 4; i++) begin
      bundle(b2b_alu[i], 32'h0, 1'b1, b2b_reg[i], 1'b0, 1'b0);
      check("b2b_ready", 32'(ex_ready), 32'd1);
      tick();
      check("b2b_wben", 32'(wb_en), (i == 0) ? 32'd0 : 32'd1);
      check("b2b_wbreg", 32'(wb_reg), 32'(b2b_reg[i]));
      check("b2b_wbdata", wb_data, b2b_alu[i]);
    end
    ex_valid = 1'b0;
    tick();
    check("b2b_idle_wben", 32'(wb_en), 32'd0);

    // Reset in 2nd ACCESS cycle, late ack afterwards
    bundle(32'h8, 32'h0, 1'b1, 5'd10, 1'b0, 1'b1);
    tick();
    ex_valid = 1'b0;
    check("rstacc_req1", 32'(dmem_req), 32'd1);
    tick();
    check("rstacc_req2", 32'(dmem_req), 32'd1);
    rst = 1'b1;
    tick();
    check_all_zero("rstacc");
    rst = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
    #1;
    check("rstacc_ready", 32'(ex_ready), 32'd1);
    tick();
    dmem_ack = 1'b0;
    check("late_ack_wben", 32'(wb_en), 32'd0);
    check("late_ack_req", 32'(dmem_req), 32'd0);
    tick();
    check("late_ack_wben2", 32'(wb_en), 32'd0);

    // Load with no ack
    bundle(32'h20, 32'h0, 1'b1, 5'd12, 1'b0, 1'b1);
    tick();
    ex_valid = 1'b0;
`ifdef MEM_TIMEOUT_EN
    for (int k = 1; k <= 16; k++) begin
      check("to_req", 32'(dmem_req), 32'd1);
      check("to_err_low", 32'(mem_err), 32'd0);
      tick();
    end
    check("to_req_drop", 32'(dmem_req), 32'd0);
    check("to_err", 32'(mem_err), 32'd1);
    check("to_no_wb", 32'(wb_en), 32'd0);
    check("to_ready", 32'(ex_ready), 32'd1);
    tick(); tick();
    check("to_err_sticky", 32'(mem_err), 32'd1);
    check("to_no_wb2", 32'(wb_en), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("to_err_cleared", 32'(mem_err), 32'd0);
`else
    for (int k = 1; k <= 20; k++) begin
      check("noto_req", 32'(dmem_req), 32'd1);
      check("noto_err", 32'(mem_err), 32'd0);
      check("noto_wben", 32'(wb_en), 32'd0);
      tick();
    end
    dmem_ack = 1'b1; dmem_rdata = 32'h0BADF00D;
    tick();
    dmem_ack = 1'b0;
    check("noto_wben_end", 32'(wb_en), 32'd1);
    check("noto_wbdata", wb_data, 32'h0BADF00D);
    check("noto_err_end", 32'(mem_err), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
